// File: rtl/lcd_saida_dados.sv
// HD44780 8-bit write driver: power-on init, then signed 32-bit values as
// right-justified decimal on LCD line 1.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   out, dados        one-cycle write strobe and two's-complement value
//   busy              high while initialising/transmitting; writes need busy=0
//   perdido           sticky flag: a write arrived while busy
//   LCD_RS/RW/EN/DATA HD44780 bus (RW tied low, DATA always driven)
module lcd_saida_dados #(
    parameter int INIT_WAIT = 750000,
    parameter int EN_CYCLES = 16,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out,
    input  logic [31:0] dados,
    output logic        busy,
    output logic        perdido,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic [7:0]  LCD_DATA
);

    typedef enum logic [2:0] {
        S_INIT_WAIT, S_INIT_CMD, S_IDLE, S_CONVERT,
        S_LOAD_BYTE, S_EN_HIGH, S_EN_LOW
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        frame_q, frame_d;
    logic        neg_q, neg_d;
    logic        nz_q, nz_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic        perdido_q, perdido_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;

    logic [3:0]  idx_n;
    logic [3:0]  dig;
    logic [31:0] low_last;
    logic [71:0] conv;

    function automatic logic [7:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    function automatic logic [39:0] add3(input logic [39:0] b);
        logic [39:0] r;
        r = b;
        for (int i = 0; i < 10; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign idx_n = idx_q + 4'd1;
    // Digits leave MSD first; bcd_q is shifted left after each one.
    assign dig   = bcd_q[39:36];
    assign conv  = {add3(bcd_q), bin_q} << 1;
    // Clear display needs the long settle time.
    assign low_last = (!rs_q && data_q == 8'h01) ?
                      32'(CLR_WAIT - 1) : 32'(CMD_WAIT - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        neg_d     = neg_q;
        nz_d      = nz_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        perdido_d = perdido_q | (out & busy_q);
        rs_d      = rs_q;
        en_d      = en_q;
        data_d    = data_q;
        unique case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == 32'(INIT_WAIT - 1)) begin
                    state_d = S_INIT_CMD;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(4'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_INIT_CMD, S_LOAD_BYTE: begin
                state_d = S_EN_HIGH;
                en_d    = 1'b1;
                cnt_d   = '0;
            end
            S_EN_HIGH: begin
                if (cnt_q == 32'(EN_CYCLES - 1)) begin
                    state_d = S_EN_LOW;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_EN_LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d = '0;
                    if (!frame_q) begin
                        if (idx_q == 4'd3) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_INIT_CMD;
                            idx_d   = idx_n;
                            data_d  = init_byte(idx_n);
                        end
                    end else if (idx_q == 4'd11) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD_BYTE;
                        idx_d   = idx_n;
                        rs_d    = 1'b1;
                        if (idx_n == 4'd1) begin
                            data_d = neg_q ? 8'h2D : 8'h20;
                        end else begin
                            bcd_d = bcd_q << 4;
                            nz_d  = nz_q | (dig != 4'd0);
                            // Blank leading zeros; last column always shows.
                            if (nz_q || dig != 4'd0 || idx_n == 4'd11)
                                data_d = {4'h3, dig};
                            else
                                data_d = 8'h20;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                // busy stays high for the first IDLE cycle after a transfer.
                if (out && !busy_q) begin
                    state_d = S_CONVERT;
                    busy_d  = 1'b1;
                    frame_d = 1'b1;
                    neg_d   = dados[31];
                    bin_d   = dados[31] ? (~dados + 32'd1) : dados;
                    bcd_d   = '0;
                    nz_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_CONVERT: begin
                bcd_d = conv[71:32];
                bin_d = conv[31:0];
                if (cnt_q == 32'd31) begin
                    state_d = S_LOAD_BYTE;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    rs_d    = 1'b0;
                    data_d  = 8'h80;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_INIT_WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= 1'b0;
            neg_q     <= 1'b0;
            nz_q      <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b1;
            perdido_q <= 1'b0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            neg_q     <= neg_d;
            nz_q      <= nz_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            perdido_q <= perdido_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            data_q    <= data_d;
        end
    end

    assign busy     = busy_q;
    assign perdido  = perdido_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;
    assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_saida_dados.sv
// Directed bench for lcd_saida_dados: init sequence, frames, timing,
// lost writes and mid-frame reset.
module tb_lcd_saida_dados;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        out   = 1'b0;
    logic [31:0] dados = '0;
    logic        busy, perdido, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0]  LCD_DATA;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rst_cyc = 0;

    logic [8:0] bytes[$];
    int         rises[$];
    int         falls[$];
    logic       prev_en = 1'b0;

    lcd_saida_dados #(
        .INIT_WAIT(100),
        .EN_CYCLES(4),
        .CMD_WAIT (20),
        .CLR_WAIT (50)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .out     (out),
        .dados   (dados),
        .busy    (busy),
        .perdido (perdido),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN),
        .LCD_DATA(LCD_DATA)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Byte capture on EN falling edge, sampled on the inactive edge.
    always @(negedge clock) begin
        if (!prev_en && LCD_EN === 1'b1) rises.push_back(cyc);
        if (prev_en && LCD_EN === 1'b0) begin
            bytes.push_back({LCD_RS, LCD_DATA});
            falls.push_back(cyc);
        end
        prev_en = (LCD_EN === 1'b1);
    end

    task automatic clear_log();
        bytes.delete();
        rises.delete();
        falls.delete();
    endtask

    task automatic wait_idle(output int c, output bit ok);
        ok = 1'b0;
        c  = cyc;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    // Caller is at a negedge; value is taken at the next posedge.
    task automatic send(input logic [31:0] v, output int ca);
        out   = 1'b1;
        dados = v;
        @(negedge clock);
        out = 1'b0;
        ca  = cyc;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        rst_cyc = cyc;
        got = {busy, perdido, LCD_RS, LCD_RW, LCD_EN, LCD_DATA};
        n_cmp++;
        if (got !== 13'h1000) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want %h", got, 13'h1000);
        end
        @(posedge clock);
        #1 clear_log();
    endtask

    task automatic test_init();
        int c;
        bit ok;
        logic [8:0] exp[$];
        wait_idle(c, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL init_timeout: busy got 1 want 0");
        end
        n_cmp++;
        if (c - rst_cyc != 231) begin
            n_bad++;
            $display("FAIL init_busy_fall: got %0d want 231", c - rst_cyc);
        end
        exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL init_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL init_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
        n_cmp++;
        if (rises.size() != 4 || falls.size() != 4) begin
            n_bad++;
            $display("FAIL init_edges: got %0d/%0d want 4/4",
                     rises.size(), falls.size());
        end else begin
            n_cmp++;
            if (rises[0] - rst_cyc != 101) begin
                n_bad++;
                $display("FAIL init_first_en: got %0d want 101", rises[0] - rst_cyc);
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rises[i+1] - falls[i] - 1 != ((i == 2) ? 50 : 20)) begin
                    n_bad++;
                    $display("FAIL init_gap%0d: got %0d want %0d", i,
                             rises[i+1] - falls[i] - 1, (i == 2) ? 50 : 20);
                end
            end
        end
    endtask

    task automatic test_positive();
        int ca, c;
        bit ok;
        logic [8:0] exp[$];
        clear_log();
        send(32'h0000007B, ca);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pos_busy_rise: got %b want 1", busy);
        end
        wait_idle(c, ok);
        n_cmp++;
        if (!ok || c - ca != 333) begin
            n_bad++;
            $display("FAIL pos_latency: got %0d want 333", c - ca);
        end
        exp.push_back(9'h080);
        repeat (8) exp.push_back(9'h120);
        exp.push_back(9'h131);
        exp.push_back(9'h132);
        exp.push_back(9'h133);
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL pos_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL pos_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ca, c;
        bit ok;
        logic [8:0] exp[$];
        clear_log();
        send(32'h00000000, ca);
        wait_idle(c, ok);
        exp.push_back(9'h080);
        repeat (10) exp.push_back(9'h120);
        exp.push_back(9'h130);
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL zero_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL zero_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
        clear_log();
        exp.delete();
        send(32'hFFFFFFFF, ca);
        n_cmp++;
        if ({busy, perdido} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_accept: got %b want 10", {busy, perdido});
        end
        wait_idle(c, ok);
        n_cmp++;
        if (!ok || c - ca != 333) begin
            n_bad++;
            $display("FAIL neg_latency: got %0d want 333", c - ca);
        end
        exp.push_back(9'h080);
        exp.push_back(9'h12D);
        repeat (9) exp.push_back(9'h120);
        exp.push_back(9'h131);
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL neg_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL neg_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
    endtask

    task automatic test_min();
        int ca, c;
        bit ok;
        logic [8:0] exp[$];
        clear_log();
        send(32'h80000000, ca);
        wait_idle(c, ok);
        exp = '{9'h080, 9'h12D, 9'h132, 9'h131, 9'h134, 9'h137,
                9'h134, 9'h138, 9'h133, 9'h136, 9'h134, 9'h138};
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL min_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL min_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
    endtask

    task automatic test_lost();
        int ca, c;
        bit ok;
        logic [8:0] exp[$];
        clear_log();
        send(32'd5, ca);
        repeat (100) @(negedge clock);
        out   = 1'b1;
        dados = 32'd999;
        @(negedge clock);
        out = 1'b0;
        n_cmp++;
        if (perdido !== 1'b1) begin
            n_bad++;
            $display("FAIL lost_flag: got %b want 1", perdido);
        end
        wait_idle(c, ok);
        n_cmp++;
        if (!ok || c - ca != 333) begin
            n_bad++;
            $display("FAIL lost_latency: got %0d want 333", c - ca);
        end
        exp.push_back(9'h080);
        repeat (10) exp.push_back(9'h120);
        exp.push_back(9'h135);
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL lost_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL lost_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
        clear_log();
        send(32'd7, ca);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL lost_next_accept: got %b want 1", busy);
        end
        wait_idle(c, ok);
        n_cmp++;
        if (bytes.size() != 12 || bytes[11] !== 9'h137) begin
            n_bad++;
            $display("FAIL lost_next_frame: got %0d bytes, last %h want 12, 137",
                     bytes.size(), (bytes.size() > 11) ? bytes[11] : 9'h1ff);
        end
        n_cmp++;
        if (perdido !== 1'b1) begin
            n_bad++;
            $display("FAIL lost_sticky: got %b want 1", perdido);
        end
    endtask

    task automatic test_reset_mid();
        int ca, c, c0;
        bit ok;
        logic [12:0] got;
        logic [8:0] exp[$];
        clear_log();
        send(32'h0000007B, ca);
        repeat (160) @(negedge clock);
        n_cmp++;
        if (bytes.size() != 5 || LCD_EN !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got %0d bytes en %b want 5 bytes en 1",
                     bytes.size(), LCD_EN);
        end
        // Reset and a write strobe in the same cycle.
        reset = 1'b1;
        out   = 1'b1;
        dados = 32'd42;
        @(negedge clock);
        reset = 1'b0;
        out   = 1'b0;
        c0    = cyc;
        got = {busy, perdido, LCD_RS, LCD_RW, LCD_EN, LCD_DATA};
        n_cmp++;
        if (got !== 13'h1000) begin
            n_bad++;
            $display("FAIL mid_reset_outs: got %h want %h", got, 13'h1000);
        end
        @(posedge clock);
        #1 clear_log();
        repeat (20) @(negedge clock);
        out = 1'b1;
        @(negedge clock);
        out = 1'b0;
        n_cmp++;
        if (perdido !== 1'b1) begin
            n_bad++;
            $display("FAIL init_lost_flag: got %b want 1", perdido);
        end
        wait_idle(c, ok);
        n_cmp++;
        if (!ok || c - c0 != 231) begin
            n_bad++;
            $display("FAIL mid_init_done: got %0d want 231", c - c0);
        end
        n_cmp++;
        if (rises.size() < 1 || rises[0] - c0 != 101) begin
            n_bad++;
            $display("FAIL mid_first_en: got %0d want 101",
                     (rises.size() > 0) ? rises[0] - c0 : -1);
        end
        repeat (60) @(negedge clock);
        exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
        n_cmp++;
        if (bytes.size() != exp.size()) begin
            n_bad++;
            $display("FAIL mid_len: got %0d want %0d", bytes.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (i >= bytes.size() || bytes[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL mid_byte%0d: got %h want %h", i,
                         (i < bytes.size()) ? bytes[i] : 9'h1ff, exp[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_idle: busy got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_positive();
        test_back_to_back();
        test_min();
        test_lost();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
